pwm_bank: RTL and testbench

//  Parametrised N-channel PWM bank with a memory-mapped register file, the successor to the fixed 8-servo top.

---
 rtl/pwm_bank_pkg.sv | 23 ++
 rtl/pwm_chan.sv | 87 ++++++++
 rtl/pwm_bank.sv | 90 +++++++++
 tb/tb_pwm_bank.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_bank_pkg.sv
// Shared definitions for the PWM bank: register map offsets, CTRL bit layout
// and the per-channel FSM state type.
package pwm_bank_pkg;

    localparam int CH_STRIDE = 16;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_DUTY   = 2'd1;
    localparam logic [1:0] REG_PERIOD = 2'd2;
    localparam logic [1:0] REG_COUNT  = 2'd3;

    localparam logic [1:0] REG_SYNC   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_POL_BIT = 1;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } chan_state_e;

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: shadowed DUTY/PERIOD, active copies reloaded at period end,
// free-running counter, polarity and a registered output.
module pwm_chan
    import pwm_bank_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             res,
    input  logic             ctrl_we,
    input  logic             duty_we,
    input  logic             period_we,
    input  logic             sync,
    input  logic [1:0]       ctrl_wdata,
    input  logic [CNT_W-1:0] wdata,
    output logic             en,
    output logic             pol,
    output logic [CNT_W-1:0] duty_sh,
    output logic [CNT_W-1:0] period_sh,
    output logic [CNT_W-1:0] cnt,
    output logic             pwm,
    output logic             period_end
);

    chan_state_e      state, state_d;
    logic [CNT_W-1:0] duty_act, period_act, cnt_d;
    logic             en_d, load;

    assign en   = (state == CH_RUN);
    assign en_d = ctrl_we ? ctrl_wdata[CTRL_EN_BIT] : en;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = en_d ? CH_RUN : CH_IDLE;
        cnt_d      = cnt;
        load       = 1'b0;
        period_end = 1'b0;
        case (state)
            CH_IDLE: begin
                cnt_d = '0;
                load  = en_d;
            end
            CH_RUN: begin
                if (!en_d) begin
                    cnt_d = '0;
                end else if (sync || period_act == '0) begin
                    // With no period running, keep tracking the shadow so a new PERIOD starts the channel.
                    cnt_d = '0;
                    load  = 1'b1;
                end else if (cnt == period_act - CNT_W'(1)) begin
                    cnt_d      = '0;
                    load       = 1'b1;
                    period_end = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!res) begin
            state      <= CH_IDLE;
            pol        <= 1'b0;
            duty_sh    <= '0;
            period_sh  <= '0;
            duty_act   <= '0;
            period_act <= '0;
            cnt        <= '0;
            pwm        <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (ctrl_we)   pol       <= ctrl_wdata[CTRL_POL_BIT];
            if (duty_we)   duty_sh   <= wdata;
            if (period_we) period_sh <= wdata;
            // A shadow write on the reload edge is not seen until the next period.
            if (load) begin
                duty_act   <= duty_sh;
                period_act <= period_sh;
            end
            pwm <= (en && period_act != '0 && cnt < duty_act) ^ pol;
        end
    end

endmodule

// File: rtl/pwm_bank.sv
// N-channel PWM bank with a memory-mapped register file: address decode,
// registered read mux, multi-channel SYNC and W1C period-end STATUS.
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int N_CH   = 8,
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              res,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic [N_CH-1:0]   pwm
);

    localparam int CH_SHIFT = $clog2(CH_STRIDE);
    localparam int CH_W     = ADDR_W - CH_SHIFT;

    logic [CH_W-1:0]  ch_sel;
    logic [1:0]       reg_sel;
    logic             sync_hit, status_hit;
    logic [N_CH-1:0]  en_v, pol_v, period_end_v, status;
    logic [CNT_W-1:0] duty_a [N_CH];
    logic [CNT_W-1:0] period_a [N_CH];
    logic [CNT_W-1:0] cnt_a [N_CH];
    logic [31:0]      rdata;
    logic             unused_addr_lsb;

    assign ch_sel          = addr[ADDR_W-1:CH_SHIFT];
    assign reg_sel         = addr[CH_SHIFT-1:2];
    assign unused_addr_lsb = ^addr[1:0];
    assign sync_hit        = wr && ch_sel == CH_W'(N_CH) && reg_sel == REG_SYNC;
    assign status_hit      = wr && ch_sel == CH_W'(N_CH) && reg_sel == REG_STATUS;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        logic ch_wr;
        assign ch_wr = wr && ch_sel == CH_W'(i);

        pwm_chan #(.CNT_W(CNT_W)) u_chan (
            .clk        (clk),
            .res        (res),
            .ctrl_we    (ch_wr && reg_sel == REG_CTRL),
            .duty_we    (ch_wr && reg_sel == REG_DUTY),
            .period_we  (ch_wr && reg_sel == REG_PERIOD),
            .sync       (sync_hit && data_in[i]),
            .ctrl_wdata (data_in[1:0]),
            .wdata      (data_in[CNT_W-1:0]),
            .en         (en_v[i]),
            .pol        (pol_v[i]),
            .duty_sh    (duty_a[i]),
            .period_sh  (period_a[i]),
            .cnt        (cnt_a[i]),
            .pwm        (pwm[i]),
            .period_end (period_end_v[i])
        );
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sel == CH_W'(i)) begin
                case (reg_sel)
                    REG_CTRL:   rdata = {30'd0, pol_v[i], en_v[i]};
                    REG_DUTY:   rdata = 32'(duty_a[i]);
                    REG_PERIOD: rdata = 32'(period_a[i]);
                    REG_COUNT:  rdata = 32'(cnt_a[i]);
                endcase
            end
        end
        if (ch_sel == CH_W'(N_CH) && reg_sel == REG_STATUS) begin
            rdata = 32'(status);
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            status   <= '0;
            data_out <= '0;
        end else begin
            // Hardware set is OR-ed after the clear so a coincident set wins.
            status <= (status & ~(status_hit ? data_in[N_CH-1:0] : '0)) | period_end_v;
            if (rd && !wr) data_out <= rdata;
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// Directed self-checking bench for pwm_bank (N_CH=8, CNT_W=32, ADDR_W=8).
module tb_pwm_bank;

    logic        clk = 1'b0;
    logic        res;
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [7:0]  pwm;

    int checks   = 0;
    int failures = 0;

    pwm_bank #(.N_CH(8), .CNT_W(32), .ADDR_W(8)) dut (
        .clk      (clk),
        .res      (res),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .pwm      (pwm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Both bus tasks start just after a negedge and consume exactly one cycle.
    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        addr = a; data_in = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
        addr = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        check(tag, data_out, exp);
    endtask

    initial begin
        int d;
        res = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;

        // 1: reset
        repeat (2) @(negedge clk);
        check("rst_pwm", {24'd0, pwm}, 32'd0);
        check("rst_data_out", data_out, 32'd0);
        res = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            for (int r = 0; r < 4; r++) begin
                read_check("rst_read", 8'(c * 16 + r * 4), 32'd0);
            end
        end

        // 2: ch0 PERIOD=10 DUTY=3, COUNT streamed with rd held
        bus_write(8'h08, 32'd10);
        bus_write(8'h04, 32'd3);
        bus_write(8'h00, 32'd1);
        addr = 8'h0C; rd = 1'b1;
        @(negedge clk);
        for (int j = 2; j <= 31; j++) begin
            check("t2_pwm", {31'd0, pwm[0]}, ((j - 2) % 10 < 3) ? 32'd1 : 32'd0);
            check("t2_count", data_out, 32'((j - 2) % 10));
            @(negedge clk);
        end
        rd = 1'b0;

        // 3: DUTY=7 written mid-period, then DUTY=2 written on the period-end edge
        repeat (4) @(negedge clk);
        bus_write(8'h04, 32'd7);
        for (int j = 37; j <= 51; j++) begin
            d = (j - 1 >= 41) ? 7 : 3;
            check("t3_mid_pwm", {31'd0, pwm[0]}, ((j - 2) % 10 < d) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
        bus_write(8'h04, 32'd2);
        for (int j = 61; j <= 82; j++) begin
            d = (j - 1 >= 71) ? 2 : 7;
            check("t3_end_pwm", {31'd0, pwm[0]}, ((j - 2) % 10 < d) ? 32'd1 : 32'd0);
            @(negedge clk);
        end

        // 4: DUTY > PERIOD, PERIOD = 0, polarity
        bus_write(8'h04, 32'd12);
        repeat (9) @(negedge clk);
        for (int j = 0; j < 12; j++) begin
            check("t4_full_pwm", {31'd0, pwm[0]}, 32'd1);
            @(negedge clk);
        end
        bus_write(8'h08, 32'd0);
        repeat (7) @(negedge clk);
        for (int j = 0; j < 10; j++) begin
            check("t4_zero_period_pwm", {31'd0, pwm[0]}, 32'd0);
            @(negedge clk);
        end
        read_check("t4_zero_period_count", 8'h0C, 32'd0);
        bus_write(8'h00, 32'd0);
        bus_write(8'h08, 32'd10);
        bus_write(8'h04, 32'd3);
        check("t4_idle_pwm", {31'd0, pwm[0]}, 32'd0);
        bus_write(8'h00, 32'd3);
        @(negedge clk);
        for (int r = 2; r <= 21; r++) begin
            check("t4_pol_pwm", {31'd0, pwm[0]}, ((r - 2) % 10 < 3) ? 32'd0 : 32'd1);
            @(negedge clk);
        end
        bus_write(8'h00, 32'd2);
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            check("t4_pol_idle_pwm", {31'd0, pwm[0]}, 32'd1);
            @(negedge clk);
        end
        read_check("t4_pol_idle_count", 8'h0C, 32'd0);
        read_check("t4_ctrl_read", 8'h00, 32'd2);
        bus_write(8'h00, 32'd0);

        // 5: SYNC alignment and STATUS W1C
        bus_write(8'h08, 32'd8);
        bus_write(8'h04, 32'd4);
        bus_write(8'h18, 32'd8);
        bus_write(8'h14, 32'd4);
        bus_write(8'h00, 32'd1);
        repeat (3) @(negedge clk);
        bus_write(8'h10, 32'd1);
        bus_write(8'h80, 32'h3);
        @(negedge clk);
        for (int j = 2; j <= 17; j++) begin
            check("t5_sync_pwm", {24'd0, pwm}, ((j - 2) % 8 < 4) ? 32'h3 : 32'h0);
            @(negedge clk);
        end
        read_check("t5_count0", 8'h0C, 32'd1);
        read_check("t5_count1", 8'h1C, 32'd2);
        bus_write(8'h84, 32'h3);
        read_check("t5_status_cleared", 8'h84, 32'h0);
        repeat (3) @(negedge clk);
        read_check("t5_status_set", 8'h84, 32'h3);
        bus_write(8'h84, 32'h1);
        read_check("t5_status_w1c", 8'h84, 32'h2);
        repeat (4) @(negedge clk);
        bus_write(8'h84, 32'h1);
        read_check("t5_status_set_wins", 8'h84, 32'h3);

        // 6: bus read behaviour
        bus_write(8'h14, 32'h55);
        read_check("t6_duty_read", 8'h14, 32'h55);
        addr = 8'h14; data_in = 32'h66; rd = 1'b1; wr = 1'b1;
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        check("t6_rdwr_hold", data_out, 32'h55);
        read_check("t6_rdwr_wrote", 8'h14, 32'h66);
        read_check("t6_unmapped", 8'hF0, 32'd0);
        read_check("t6_unmapped_top", 8'h88, 32'd0);
        read_check("t6_sync_read", 8'h80, 32'd0);
        read_check("t6_ctrl0", 8'h00, 32'd1);
        read_check("t6_period1", 8'h18, 32'd8);

        // Reset mid-period at cnt=4
        bus_write(8'h00, 32'd0);
        bus_write(8'h00, 32'd1);
        repeat (4) @(negedge clk);
        check("t6_pre_reset_pwm0", {31'd0, pwm[0]}, 32'd1);
        res = 1'b0;
        @(negedge clk);
        check("t6_reset_pwm", {24'd0, pwm}, 32'd0);
        check("t6_reset_data_out", data_out, 32'd0);
        res = 1'b1;
        read_check("t6_reset_count", 8'h0C, 32'd0);
        read_check("t6_reset_ctrl", 8'h00, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
